// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO written by the core,
// drained one frame at a time onto uartTxPin at CLKS_PER_BIT clocks per bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             tx_busy,
    output logic             uartTxPin
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    logic [1:0]       state;
    logic [BW-1:0]    baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             baud_last;

    // full is the registered flag, so a push while full is dropped even if a pop happens in the same cycle
    assign push      = wr_en && !full;
    assign pop       = (state == IDLE) && !empty;
    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_FULL);
            empty <= (count_next == '0);
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_busy   <= 1'b0;
            uartTxPin <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uartTxPin <= 1'b1;
                    baud_cnt  <= '0;
                    if (!empty) begin
                        shift     <= mem[rd_ptr];
                        state     <= START;
                        tx_busy   <= 1'b1;
                        uartTxPin <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                        uartTxPin <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state     <= STOP;
                            uartTxPin <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            uartTxPin <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    baud_cnt  <= '0;
                    tx_busy   <= 1'b0;
                    uartTxPin <= 1'b1;
                end
            endcase
        end
    end

endmodule
